// File: rtl/lock_requester_pkg.sv
//------------------------------------------------------------------------------
// Package     : OmpSsManager
// Description : Constants shared by blocks that talk to the OmpSs manager lock
//               unit: lock ID width, command field bounds and the command and
//               ACK codes. It also provides a helper that builds a command beat.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package OmpSsManager;

   localparam int LOCK_ID_BITS = 8;

   // Bit positions of the fields inside a 64-bit command beat
   localparam int CMD_TYPE_H = 7;
   localparam int CMD_TYPE_L = 0;
   localparam int LOCK_ID_H  = 15;
   localparam int LOCK_ID_L  = 8;

   localparam logic [7:0] CMD_LOCK_CODE   = 8'h04;
   localparam logic [7:0] CMD_UNLOCK_CODE = 8'h05;
   localparam logic [7:0] ACK_OK_CODE     = 8'h01;
   localparam logic [7:0] ACK_REJECT_CODE = 8'h00;

   // Builds a command beat. All bits outside the two fields are zero.
   function automatic logic [63:0] make_lock_cmd(input logic [7:0]              cmd,
                                                 input logic [LOCK_ID_BITS-1:0] lock_id);
      logic [63:0] beat;
      beat = '0;
      beat[CMD_TYPE_H:CMD_TYPE_L] = cmd;
      beat[LOCK_ID_H:LOCK_ID_L]   = lock_id;
      return beat;
   endfunction

endpackage : OmpSsManager

`default_nettype wire

// File: rtl/lock_requester.sv
//------------------------------------------------------------------------------
// Module      : lock_requester
// Description : Accelerator-side initiator for the OmpSs manager lock protocol.
//               It turns single-beat lock and unlock requests into 64-bit
//               command beats. For a lock it then waits for the one-beat ACK
//               and retries on reject until the lock is granted. An unlock is
//               never acknowledged, so it completes on its command handshake.
// Revision    : 1.0 - initial release
//
// Build option: LOCK_BACKOFF_EN - when defined, the block waits BACKOFF_CYCLES
//               idle cycles after a reject before it sends the lock command
//               again. When undefined, the retry beat is valid in the cycle
//               after the reject and no backoff counter is built.
//
// Ports:
//   clk, rstn          clock; synchronous active-low reset
//   req_valid/ready    request handshake from user logic
//   req_unlock         1 = unlock, 0 = lock (sampled at acceptance)
//   req_lock_id        lock ID (sampled at acceptance)
//   done               one-cycle pulse: lock granted / unlock sent
//   held               this accelerator currently owns the lock
//   retries            rejects seen for the current or last lock request
//   outStream_*        command stream to the manager (TLAST=1, TID=ACC_ID)
//   inStream_*         ACK stream from the manager (only TDATA[7:0] is used)
//------------------------------------------------------------------------------
`default_nettype none

module lock_requester
   import OmpSsManager::*;
#(
   parameter int ACC_BITS       = 4,
   parameter int ACC_ID         = 0,
   parameter int BACKOFF_CYCLES = 16
) (
   input  logic                    clk,
   input  logic                    rstn,

   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_unlock,
   input  logic [LOCK_ID_BITS-1:0] req_lock_id,
   output logic                    done,
   output logic                    held,
   output logic [15:0]             retries,

   output logic [63:0]             outStream_TDATA,
   output logic                    outStream_TVALID,
   input  logic                    outStream_TREADY,
   output logic                    outStream_TLAST,
   output logic [ACC_BITS-1:0]     outStream_TID,

   input  logic [63:0]             inStream_TDATA,
   input  logic                    inStream_TVALID,
   output logic                    inStream_TREADY
);

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      SEND_LOCK   = 3'd1,
      WAIT_ACK    = 3'd2,
      BACKOFF     = 3'd3,
      SEND_UNLOCK = 3'd4,
      GRANT       = 3'd5
   } State_t;

   State_t      state_q;
   logic        req_ready_q;
   logic        out_tvalid_q;
   logic        in_tready_q;
   logic        done_q;
   logic        held_q;
   logic [15:0] retries_q;
   logic [15:0] retries_d;
   logic [63:0] tdata_q;

   // Reject count saturates instead of wrapping back to zero
   assign retries_d = (retries_q == 16'hFFFF) ? retries_q : retries_q + 16'd1;

`ifdef LOCK_BACKOFF_EN
   localparam int CNT_W = (BACKOFF_CYCLES > 1) ? $clog2(BACKOFF_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BACKOFF_CYCLES - 1);

   logic [CNT_W-1:0] backoff_cnt_q;

   logic unused_ok;
   assign unused_ok = &{1'b0, inStream_TDATA[63:8]};
`else
   logic unused_ok;
   assign unused_ok = &{1'b0, inStream_TDATA[63:8], (BACKOFF_CYCLES != 0)};
`endif

   // All outputs are registered and updated together with the state, so
   // there is no combinational path from any input to any output.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q      <= IDLE;
         req_ready_q  <= 1'b1;
         out_tvalid_q <= 1'b0;
         in_tready_q  <= 1'b0;
         done_q       <= 1'b0;
         held_q       <= 1'b0;
         retries_q    <= 16'd0;
         tdata_q      <= 64'd0;
`ifdef LOCK_BACKOFF_EN
         backoff_cnt_q <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (req_valid && req_ready_q) begin
                  req_ready_q  <= 1'b0;
                  out_tvalid_q <= 1'b1;
                  if (req_unlock) begin
                     tdata_q <= make_lock_cmd(CMD_UNLOCK_CODE, req_lock_id);
                     state_q <= SEND_UNLOCK;
                  end else begin
                     tdata_q   <= make_lock_cmd(CMD_LOCK_CODE, req_lock_id);
                     retries_q <= 16'd0;
                     state_q   <= SEND_LOCK;
                  end
               end else begin
                  // Re-opens acceptance one cycle after an unlock's done pulse
                  req_ready_q <= 1'b1;
               end
            end

            SEND_LOCK: begin
               if (outStream_TREADY) begin
                  out_tvalid_q <= 1'b0;
                  in_tready_q  <= 1'b1;
                  state_q      <= WAIT_ACK;
               end
            end

            SEND_UNLOCK: begin
               // The unlock completes here; the responder never answers it
               if (outStream_TREADY) begin
                  out_tvalid_q <= 1'b0;
                  done_q       <= 1'b1;
                  held_q       <= 1'b0;
                  state_q      <= IDLE;
               end
            end

            WAIT_ACK: begin
               if (inStream_TVALID) begin
                  in_tready_q <= 1'b0;
                  if (inStream_TDATA[7:0] == ACK_OK_CODE) begin
                     done_q  <= 1'b1;
                     held_q  <= 1'b1;
                     state_q <= GRANT;
                  end else begin
                     // Anything other than OK counts as a reject
                     retries_q <= retries_d;
`ifdef LOCK_BACKOFF_EN
                     backoff_cnt_q <= CNT_LOAD;
                     state_q       <= BACKOFF;
`else
                     out_tvalid_q  <= 1'b1;
                     state_q       <= SEND_LOCK;
`endif
                  end
               end
            end

            BACKOFF: begin
`ifdef LOCK_BACKOFF_EN
               if (backoff_cnt_q == '0) begin
                  out_tvalid_q <= 1'b1;
                  state_q      <= SEND_LOCK;
               end else begin
                  backoff_cnt_q <= backoff_cnt_q - 1'b1;
               end
`else
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
`endif
            end

            GRANT: begin
               req_ready_q <= 1'b1;
               state_q     <= IDLE;
            end

            default: begin
               req_ready_q  <= 1'b1;
               out_tvalid_q <= 1'b0;
               in_tready_q  <= 1'b0;
               state_q      <= IDLE;
            end
         endcase
      end
   end

   assign req_ready        = req_ready_q;
   assign done             = done_q;
   assign held             = held_q;
   assign retries          = retries_q;
   assign outStream_TDATA  = tdata_q;
   assign outStream_TVALID = out_tvalid_q;
   assign outStream_TLAST  = 1'b1;
   assign outStream_TID    = ACC_BITS'(ACC_ID);
   assign inStream_TREADY  = in_tready_q;

endmodule : lock_requester

`default_nettype wire

// File: tb/tb_lock_requester.sv
//------------------------------------------------------------------------------
// Module      : tb_lock_requester
// Description : Directed self-checking bench for lock_requester. Expected
//               retry spacing follows LOCK_BACKOFF_EN.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_lock_requester;
   import OmpSsManager::*;

   localparam int ACC_BITS = 4;
   localparam int ACC_ID   = 5;
   localparam int BACKOFF  = 4;
`ifdef LOCK_BACKOFF_EN
   localparam int EXP_GAP  = BACKOFF;
`else
   localparam int EXP_GAP  = 0;
`endif

   logic                clk;
   logic                rstn;
   logic                req_valid;
   logic                req_ready;
   logic                req_unlock;
   logic [7:0]          req_lock_id;
   logic                done;
   logic                held;
   logic [15:0]         retries;
   logic [63:0]         out_tdata;
   logic                out_tvalid;
   logic                out_tready;
   logic                out_tlast;
   logic [ACC_BITS-1:0] out_tid;
   logic [63:0]         in_tdata;
   logic                in_tvalid;
   logic                in_tready;

   int checks;
   int errors;

   lock_requester #(
      .ACC_BITS      (ACC_BITS),
      .ACC_ID        (ACC_ID),
      .BACKOFF_CYCLES(BACKOFF)
   ) dut (
      .clk             (clk),
      .rstn            (rstn),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_unlock      (req_unlock),
      .req_lock_id     (req_lock_id),
      .done            (done),
      .held            (held),
      .retries         (retries),
      .outStream_TDATA (out_tdata),
      .outStream_TVALID(out_tvalid),
      .outStream_TREADY(out_tready),
      .outStream_TLAST (out_tlast),
      .outStream_TID   (out_tid),
      .inStream_TDATA  (in_tdata),
      .inStream_TVALID (in_tvalid),
      .inStream_TREADY (in_tready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change and outputs are sampled on the falling edge
   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Lock request answered by n_rej rejects of value rej_val, then OK
   task automatic do_lock(input logic [7:0] id, input int n_rej, input logic [7:0] rej_val);
      int g;
      req_valid   = 1'b1;
      req_unlock  = 1'b0;
      req_lock_id = id;
      out_tready  = 1'b1;
      step();
      req_valid = 1'b0;
      for (int b = 0; b <= n_rej; b++) begin
         g = 0;
         while (!out_tvalid && g < 40) begin
            step();
            g++;
         end
         if (b == 0) chk("first_beat_lat", 64'(g), 64'd0);
         else        chk("retry_gap", 64'(g), 64'(EXP_GAP));
         chk("lock_tdata", out_tdata, {48'd0, id, 8'h04});
         chk("lock_tid", 64'(out_tid), 64'(ACC_ID));
         chk("lock_tlast", 64'(out_tlast), 64'd1);
         chk("busy_req_ready", 64'(req_ready), 64'd0);
         step();
         chk("ack_tready", 64'(in_tready), 64'd1);
         in_tvalid = 1'b1;
         in_tdata  = (b < n_rej) ? {56'hA5A5_A5A5_A5A5_A5, rej_val}
                                 : 64'hFFFF_FFFF_FFFF_FF01;
         step();
         in_tvalid = 1'b0;
         chk("ack_tready_drop", 64'(in_tready), 64'd0);
         if (b < n_rej) begin
            chk("reject_retries", 64'(retries), 64'(b + 1));
            chk("reject_no_done", 64'(done), 64'd0);
         end else begin
            chk("grant_done", 64'(done), 64'd1);
            chk("grant_held", 64'(held), 64'd1);
            chk("grant_retries", 64'(retries), 64'(n_rej));
            chk("grant_req_ready", 64'(req_ready), 64'd0);
         end
      end
      step();
      chk("lock_idle_done", 64'(done), 64'd0);
      chk("lock_idle_ready", 64'(req_ready), 64'd1);
   endtask

   // Unlock request with the command stream stalled for 'stall' cycles
   task automatic do_unlock(input logic [7:0] id, input int stall);
      req_valid   = 1'b1;
      req_unlock  = 1'b1;
      req_lock_id = id;
      out_tready  = 1'b0;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < stall; i++) begin
         chk("unl_stall_valid", 64'(out_tvalid), 64'd1);
         chk("unl_stall_tdata", out_tdata, {48'd0, id, 8'h05});
         chk("unl_in_tready", 64'(in_tready), 64'd0);
         step();
      end
      chk("unl_valid", 64'(out_tvalid), 64'd1);
      chk("unl_tdata", out_tdata, {48'd0, id, 8'h05});
      out_tready = 1'b1;
      step();
      chk("unl_done", 64'(done), 64'd1);
      chk("unl_held", 64'(held), 64'd0);
      chk("unl_tvalid_drop", 64'(out_tvalid), 64'd0);
      chk("unl_req_ready", 64'(req_ready), 64'd0);
      chk("unl_in_tready2", 64'(in_tready), 64'd0);
      step();
      chk("unl_idle_done", 64'(done), 64'd0);
      chk("unl_idle_ready", 64'(req_ready), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      checks      = 0;
      errors      = 0;
      rstn        = 1'b0;
      req_valid   = 1'b0;
      req_unlock  = 1'b0;
      req_lock_id = 8'd0;
      out_tready  = 1'b0;
      in_tdata    = 64'd0;
      in_tvalid   = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);

      chk("rst_req_ready", 64'(req_ready), 64'd1);
      chk("rst_tvalid", 64'(out_tvalid), 64'd0);
      chk("rst_in_tready", 64'(in_tready), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_held", 64'(held), 64'd0);
      chk("rst_retries", 64'(retries), 64'd0);
      chk("rst_tid", 64'(out_tid), 64'(ACC_ID));
      rstn = 1'b1;
      step();

      do_lock(8'h03, 0, 8'h00);
      do_unlock(8'h03, 5);
      do_lock(8'h03, 2, 8'h00);
      do_unlock(8'h03, 0);
      do_lock(8'h11, 0, 8'h00);

      // Second lock while held (sent unchanged), then reset in WAIT_ACK
      req_valid   = 1'b1;
      req_unlock  = 1'b0;
      req_lock_id = 8'h07;
      out_tready  = 1'b1;
      step();
      req_valid = 1'b0;
      chk("rl_tvalid", 64'(out_tvalid), 64'd1);
      chk("rl_tdata", out_tdata, 64'h0704);
      step();
      chk("rl_wait_tready", 64'(in_tready), 64'd1);
      rstn = 1'b0;
      step();
      rstn = 1'b1;
      chk("rl_req_ready", 64'(req_ready), 64'd1);
      chk("rl_held", 64'(held), 64'd0);
      chk("rl_tvalid_off", 64'(out_tvalid), 64'd0);
      chk("rl_in_tready", 64'(in_tready), 64'd0);

      // Late ACK must wait until a new lock reaches WAIT_ACK
      in_tvalid = 1'b1;
      in_tdata  = 64'h01;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("late_ack_blocked", 64'(in_tready), 64'd0);
         chk("late_ack_no_done", 64'(done), 64'd0);
      end
      req_valid   = 1'b1;
      req_lock_id = 8'h09;
      step();
      req_valid = 1'b0;
      chk("late_tdata", out_tdata, 64'h0904);
      step();
      chk("late_wait_tready", 64'(in_tready), 64'd1);
      step();
      in_tvalid = 1'b0;
      chk("late_done", 64'(done), 64'd1);
      chk("late_held", 64'(held), 64'd1);
      step();

      do_unlock(8'h09, 0);
      do_lock(8'h02, 1, 8'h7F);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_lock_requester

`default_nettype wire
